// File: rtl/uart_sample_framer.sv
// uart_sample_framer: buffers I/Q sample pairs in a FIFO and serialises each
// pair into a 6-byte frame (SYNC, I_hi, I_lo, Q_hi, Q_lo, CHK) over a
// stb/data/ack byte handshake. Samples arriving while full are dropped and counted.
module uart_sample_framer #(
  parameter int unsigned SAMPLE_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  input  logic [SAMPLE_WIDTH-1:0]       i_sample_i,
  input  logic [SAMPLE_WIDTH-1:0]       i_sample_q,
  output logic                          o_stb,
  output logic [7:0]                    o_data,
  input  logic                          i_ack,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic [15:0]                   o_drop_count,
  output logic                          o_busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                    state, state_n;
  logic [2*SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [LW-1:0]             level_n;
  logic [15:0]               frm_i, frm_q;
  logic [2:0]                idx;
  logic                      pop, push, advance, last;

  function automatic logic [15:0] sext(input logic [SAMPLE_WIDTH-1:0] s);
    logic [15:0] r;
    r = {16{s[SAMPLE_WIDTH-1]}};
    r[SAMPLE_WIDTH-1:0] = s;
    return r;
  endfunction

  function automatic logic [7:0] frame_byte(input logic [2:0] k,
                                            input logic [15:0] fi,
                                            input logic [15:0] fq);
    logic [7:0] b;
    b = '0;
    case (k)
      3'd0:    b = SYNC_BYTE;
      3'd1:    b = fi[15:8];
      3'd2:    b = fi[7:0];
      3'd3:    b = fq[15:8];
      3'd4:    b = fq[7:0];
      3'd5:    b = fi[15:8] ^ fi[7:0] ^ fq[15:8] ^ fq[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

  // Next-state, pop/advance decisions, FIFO push and next level.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    advance = 1'b0;
    last    = (idx == 3'd5);
    case (state)
      S_IDLE: begin
        if (o_fifo_level != '0) begin
          pop     = 1'b1;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (i_ack) begin
          if (!last)                    advance = 1'b1;
          else if (o_fifo_level != '0)  pop     = 1'b1;
          else                          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push = i_valid && ((o_fifo_level != LW'(FIFO_DEPTH)) || pop);
    case ({push, pop})
      2'b10:   level_n = o_fifo_level + LW'(1);
      2'b01:   level_n = o_fifo_level - LW'(1);
      default: level_n = o_fifo_level;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // FIFO storage; contents need no reset since pointers gate validity.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_sample_q, i_sample_i};
  end

  // FIFO pointers, level, drop counter and busy flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_level <= '0;
      o_drop_count <= '0;
      o_busy       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      o_fifo_level <= level_n;
      if (i_valid && !push && (o_drop_count != '1))
        o_drop_count <= o_drop_count + 16'd1;
      // Computed from next values so busy lines up with registered state/level.
      o_busy <= (state_n != S_IDLE) || (level_n != '0);
    end
  end

  // Frame register and byte output; popping loads B0 directly so frames run back-to-back.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stb  <= 1'b0;
      o_data <= '0;
      idx    <= '0;
      frm_i  <= '0;
      frm_q  <= '0;
    end else if (pop) begin
      frm_i  <= sext(mem[rd_ptr][SAMPLE_WIDTH-1:0]);
      frm_q  <= sext(mem[rd_ptr][2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]);
      o_stb  <= 1'b1;
      o_data <= SYNC_BYTE;
      idx    <= '0;
    end else if (advance) begin
      o_data <= frame_byte(idx + 3'd1, frm_i, frm_q);
      idx    <= idx + 3'd1;
    end else if (state_n == S_IDLE) begin
      o_stb  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_sample_framer.sv
// Randomised and directed bench for uart_sample_framer against a queue-based frame model.
module tb_uart_sample_framer;

  localparam int SW    = 12;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          ack = 1'b0;
  logic [SW-1:0] si = '0;
  logic [SW-1:0] sq = '0;
  logic          o_stb;
  logic [7:0]    o_data;
  logic [LW-1:0] o_fifo_level;
  logic [15:0]   o_drop_count;
  logic          o_busy;

  always #5 clk = ~clk;

  uart_sample_framer #(
    .SAMPLE_WIDTH(SW),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_sample_i  (si),
    .i_sample_q  (sq),
    .o_stb       (o_stb),
    .o_data      (o_data),
    .i_ack       (ack),
    .o_fifo_level(o_fifo_level),
    .o_drop_count(o_drop_count),
    .o_busy      (o_busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queue of pending pairs plus the frame currently on the wire.
  int unsigned mq[$];
  logic [7:0]  frame [6];
  int          pos = 0;
  bit          active = 0;
  int unsigned drops = 0;
  logic [7:0]  mdata = '0;
  logic [7:0]  got_bytes[$];

  logic [7:0] e1 [6] = '{8'hA5, 8'h01, 8'h23, 8'hFF, 8'h00, 8'hDD};
  logic [7:0] e6 [6] = '{8'hA5, 8'hF8, 8'h00, 8'h07, 8'hFF, 8'h00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to16(input int unsigned v);
    if (v >= (1 << (SW - 1))) return 16'(v + 65536 - (1 << SW));
    return 16'(v);
  endfunction

  task automatic load_frame(input int unsigned pair);
    logic [15:0] iv, qv;
    iv = to16(pair & ((1 << SW) - 1));
    qv = to16((pair >> 16) & ((1 << SW) - 1));
    frame[0] = 8'hA5;
    frame[1] = iv[15:8];
    frame[2] = iv[7:0];
    frame[3] = qv[15:8];
    frame[4] = qv[7:0];
    frame[5] = frame[1] ^ frame[2] ^ frame[3] ^ frame[4];
  endtask

  task automatic model_update(input bit v, input int unsigned i_s, input int unsigned q_s,
                              input bit a, input bit r);
    int  lvl;
    bit  popped;
    int unsigned mask;
    mask = (1 << SW) - 1;
    if (!r) begin
      mq.delete();
      active = 0;
      pos    = 0;
      drops  = 0;
      mdata  = '0;
      return;
    end
    lvl    = mq.size();
    popped = 0;
    if (!active) begin
      if (lvl > 0) popped = 1;
    end else if (a) begin
      if (pos < 5)      pos++;
      else if (lvl > 0) popped = 1;
      else              active = 0;
    end
    if (popped) begin
      load_frame(mq.pop_front());
      pos    = 0;
      active = 1;
    end
    if (v) begin
      if (lvl < DEPTH || popped) mq.push_back(((q_s & mask) << 16) | (i_s & mask));
      else if (drops < 65535) drops++;
    end
    if (active) mdata = frame[pos];
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input bit v, input int unsigned i_s, input int unsigned q_s,
                      input bit a, input bit r, input bit chk);
    valid = v;
    si    = SW'(i_s);
    sq    = SW'(q_s);
    ack   = a;
    rst_n = r;
    if (a && o_stb && r) got_bytes.push_back(o_data);
    @(posedge clk);
    model_update(v, i_s, q_s, a, r);
    #1;
    if (chk) begin
      check("stb",   32'(o_stb),        32'(active));
      check("level", 32'(o_fifo_level), 32'(mq.size()));
      check("drops", 32'(o_drop_count), drops);
      check("busy",  32'(o_busy),       32'(active || mq.size() != 0));
      if (active || !r) check("data", 32'(o_data), 32'(mdata));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1, 1);
  endtask

  task automatic acks(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 1, 1, 1);
  endtask

  task automatic cmp_bytes(input string tag, input logic [7:0] e [6]);
    check({tag, "_count"}, 32'(got_bytes.size()), 32'd6);
    for (int k = 0; k < 6 && k < got_bytes.size(); k++)
      check($sformatf("%s_b%0d", tag, k), 32'(got_bytes[k]), 32'(e[k]));
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Single pair: A5,01,23,FF,00,DD; stb two edges after valid
    got_bytes.delete();
    step(1, 'h123, 'hF00, 0, 1, 1);
    check("t1_stb_early", 32'(o_stb), 32'd0);
    step(0, 0, 0, 0, 1, 1);
    check("t1_stb_latency", 32'(o_stb), 32'd1);
    acks(6);
    idle(2);
    cmp_bytes("t1", e1);

    // Back-to-back: three pairs queued while framing
    got_bytes.delete();
    step(1, $urandom, $urandom, 0, 1, 1);
    step(1, $urandom, $urandom, 0, 1, 1);
    step(1, $urandom, $urandom, 1, 1, 1);
    acks(24);
    check("t2_bytes", 32'(got_bytes.size()), 32'd18);

    // Overflow: 20 valids, no acks
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 20; k++) step(1, $urandom, $urandom, 0, 1, 1);
    check("t3_level", 32'(o_fifo_level), 32'd16);
    check("t3_drops", 32'(o_drop_count), 32'd3);

    // Full FIFO with a simultaneous pop accepts the write
    acks(5);
    step(1, $urandom, $urandom, 1, 1, 1);
    check("t4_level", 32'(o_fifo_level), 32'd16);
    check("t4_drops", 32'(o_drop_count), 32'd3);
    check("t4_sync",  32'(o_data),       32'hA5);

    // Reset mid-frame after B2 acked, then restart
    step(0, 0, 0, 0, 0, 1);
    step(1, $urandom, $urandom, 0, 1, 1);
    idle(1);
    acks(3);
    step(0, 0, 0, 0, 0, 1);
    check("t5_stb",   32'(o_stb),        32'd0);
    check("t5_level", 32'(o_fifo_level), 32'd0);
    check("t5_drops", 32'(o_drop_count), 32'd0);
    step(1, $urandom, $urandom, 0, 1, 1);
    idle(1);
    check("t5_restart", 32'(o_data), 32'hA5);

    // Sign extension
    step(0, 0, 0, 0, 0, 1);
    got_bytes.delete();
    step(1, 'h800, 'h7FF, 0, 1, 1);
    idle(1);
    acks(6);
    idle(1);
    cmp_bytes("t6", e6);

    // Random traffic with varying load and occasional resets
    for (int blk = 0; blk < 15; blk++) begin
      int unsigned pv, pa;
      pv = $urandom_range(0, 100);
      pa = $urandom_range(0, 100);
      for (int k = 0; k < 200; k++)
        step($urandom_range(0, 99) < pv, $urandom, $urandom,
             $urandom_range(0, 99) < pa, $urandom_range(0, 599) != 0, 1);
    end

    // Drop counter saturation under sustained overflow
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 65570; k++) step(1, $urandom, $urandom, 0, 1, 0);
    step(1, $urandom, $urandom, 0, 1, 1);
    check("sat_drops", 32'(o_drop_count), 32'hFFFF);
    step(0, 0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
